axi4_pkt_wrr_sched: RTL
=======================

Name: axi4_pkt_wrr_sched

Overview:
Packet-level weighted round-robin scheduler for an N-input AXI4-Stream switch mux. It watches per-input tvalid and the switch output handshake, then issues a registered one-hot grant. The grant is held for whole packets and is never taken away mid-packet, except by watchdog timeout. The switch datapath uses grant_o to select its input and suppress_o to gate tready on ungranted inputs.

Parameters:
NUM_IN, 4, number of requesting input ports (>=2)
WEIGHT_W, 4, width of per-port weight (packets per grant turn)
TIMEOUT_W, 16, width of stall watchdog counter/threshold

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous active-high reset
en_i  in  1  scheduler enable; low blocks new grants only
req_i  in  NUM_IN  per-input tvalid (request)
cfg_weight_i  in  NUM_IN*WEIGHT_W  per-port weight, port k at [k*WEIGHT_W +: WEIGHT_W]
cfg_timeout_i  in  TIMEOUT_W  stall cycles before forced release; 0 disables
m_tvalid_i  in  1  switch output tvalid
m_tready_i  in  1  switch output tready
m_tlast_i  in  1  switch output tlast
grant_o  out  NUM_IN  registered one-hot grant; all-zero when idle
grant_valid_o  out  1  high while a grant is held
grant_idx_o  out  clog2(NUM_IN)  binary index of granted port (valid only with grant_valid_o)
suppress_o  out  NUM_IN  ~grant_o while grant_valid_o, all ones otherwise
timeout_o  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (async, rst=1): state IDLE, grant_o=0, grant_valid_o=0, grant_idx_o=0, suppress_o=all ones, timeout_o=0, rr pointer=0, credit=0, stall counter=0.
- Beat = m_tvalid_i & m_tready_i. Packet end = beat & m_tlast_i.
- States: IDLE, BUSY.
- IDLE:
  - If en_i and |req_i, pick the first set req_i bit searching upward from the rr pointer, wrapping modulo NUM_IN.
  - On the next edge: grant_o = onehot(winner), state = BUSY, credit = effective weight of winner (weight 0 treated as 1), stall counter = 0.
  - Latency from request to grant is one cycle.
  - If en_i is low or no request is present, stay in IDLE.
- BUSY:
  - Grant is held regardless of req_i and regardless of en_i.
  - On packet end with credit > 1, en_i=1 and req_i[granted]=1 in the same cycle: keep the grant, credit decrements by 1.
  - On any other packet end: release to IDLE, rr pointer = granted index + 1 (mod NUM_IN). This gives a one-cycle gap with no grant.
- Stall watchdog:
  - In BUSY, the counter increments each cycle without a beat and clears on every beat.
  - When cfg_timeout_i != 0 and counter+1 == cfg_timeout_i: release to IDLE, pointer advances as above, timeout_o=1 for that single cycle.
  - When cfg_timeout_i == 0, the counter saturates and never fires.
- Simultaneous packet end and timeout in one cycle: treat as packet end; timeout_o stays 0.
- Configuration (cfg_weight_i, cfg_timeout_i) is sampled when used: weight at grant load, timeout every cycle. Changes mid-turn affect only the next load.
- The scheduler never inspects tdata/tkeep/tuser.
- Single-beat packets (tlast on first beat) consume one credit.
- Reset asserted mid-packet: grant drops immediately (asynchronously). Downstream recovery is the switch's responsibility.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset release, NUM_IN=4, req_i=0010 -> grant_o=0010 one cycle later; grant_idx_o=1; suppress_o=1101.
- All four ports requesting continuously, all weights=1, 3-beat packets -> grant order 0,1,2,3,0, with one idle cycle between grants.
- Weights {3,1,1,1}, all requesting, 2-beat packets -> port 0 sends 3 back-to-back packets without a grant gap, then ports 1, 2, 3 one each.
- Port 0 granted, cfg_timeout_i=8, m_tready_i held 0 after the first beat:
  - Required: release on the 8th stall cycle, timeout_o pulses once, next grant goes to port 1 if it is requesting.
  - Repeat with cfg_timeout_i=0: no release after 1000 cycles.
- en_i dropped mid-packet with weight 3 -> current packet completes, grant releases at its tlast, and no new grant is issued until en_i returns.
- rst pulsed mid-packet (asynchronous, between edges) -> grant_o=0 and suppress_o=1111 before the next edge; rr pointer=0 afterwards.

Source files
------------

// File: rtl/axi4_pkt_wrr_sched.sv
// rtl/axi4_pkt_wrr_sched.sv - packet-level weighted round-robin grant scheduler for an AXI4-Stream mux
module axi4_pkt_wrr_sched #(
  parameter int NUM_IN    = 4,
  parameter int WEIGHT_W  = 4,
  parameter int TIMEOUT_W = 16,
  localparam int IDX_W    = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en_i,
  input  logic [NUM_IN-1:0]            req_i,
  input  logic [NUM_IN*WEIGHT_W-1:0]   cfg_weight_i,
  input  logic [TIMEOUT_W-1:0]         cfg_timeout_i,
  input  logic                         m_tvalid_i,
  input  logic                         m_tready_i,
  input  logic                         m_tlast_i,
  output logic [NUM_IN-1:0]            grant_o,
  output logic                         grant_valid_o,
  output logic [IDX_W-1:0]             grant_idx_o,
  output logic [NUM_IN-1:0]            suppress_o,
  output logic                         timeout_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(NUM_IN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d, idx_d, next_ptr;
  logic [WEIGHT_W-1:0]   credit_q, credit_d, win_weight;
  logic [TIMEOUT_W-1:0]  stall_q, stall_d;
  logic [NUM_IN-1:0]     grant_d;
  logic                  timeout_d;
  logic                  beat, pkt_end, timeout_hit;
  logic                  found;
  logic [IDX_W-1:0]      winner;
  logic [IDX_W:0]        cand;

  assign beat        = m_tvalid_i & m_tready_i;
  assign pkt_end     = beat & m_tlast_i;
  assign timeout_hit = (cfg_timeout_i != '0) && ((stall_q + 1'b1) == cfg_timeout_i);
  assign next_ptr    = (grant_idx_o == LAST_IDX) ? '0 : grant_idx_o + 1'b1;

  // First requester found scanning upward from the round-robin pointer, with wrap.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  // Weight of the prospective winner, sampled only at grant load.
  always_comb begin
    win_weight = '0;
    for (int k = 0; k < NUM_IN; k++)
      if (winner == IDX_W'(k)) win_weight = cfg_weight_i[k*WEIGHT_W +: WEIGHT_W];
  end

  // Next-state logic: grant load, per-packet credit, release and stall watchdog.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = grant_idx_o;
    credit_d  = credit_q;
    stall_d   = stall_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i && found) begin
          state_d  = BUSY;
          idx_d    = winner;
          credit_d = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
          stall_d  = '0;
        end
      end
      BUSY: begin
        if (pkt_end) begin
          stall_d = '0;
          if (credit_q > WEIGHT_W'(1) && en_i && req_i[grant_idx_o]) begin
            credit_d = credit_q - 1'b1;
          end else begin
            state_d  = IDLE;
            ptr_d    = next_ptr;
            credit_d = '0;
          end
        end else if (!beat && timeout_hit) begin
          state_d   = IDLE;
          ptr_d     = next_ptr;
          credit_d  = '0;
          timeout_d = 1'b1;
        end else if (beat) begin
          stall_d = '0;
        end else if (stall_q != '1) begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // One-hot grant derived from the next state so the output can be registered.
  always_comb begin
    grant_d = '0;
    if (state_d == BUSY) grant_d[idx_d] = 1'b1;
  end

  // State and output registers; reset drops the grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      credit_q      <= '0;
      stall_q       <= '0;
      grant_o       <= '0;
      grant_valid_o <= 1'b0;
      grant_idx_o   <= '0;
      suppress_o    <= '1;
      timeout_o     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      credit_q      <= credit_d;
      stall_q       <= stall_d;
      grant_o       <= grant_d;
      grant_valid_o <= (state_d == BUSY);
      grant_idx_o   <= idx_d;
      suppress_o    <= (state_d == BUSY) ? ~grant_d : '1;
      timeout_o     <= timeout_d;
    end
  end

endmodule
